// File: rtl/vec_pe_out_collector.sv
// vec_pe_out_collector
// Gathers per-lane PE results that may finish on different cycles into full
// phits, queues them in a circular FIFO and streams them out as an AXI4-Stream
// master. almost_full throttles the operand feeder because the PE array itself
// cannot be back-pressured.
module vec_pe_out_collector #(
  parameter int SIMD_DEGREE = 16,
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 16,
  parameter int AFULL_SLACK = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SIMD_DEGREE*DWIDTH-1:0]       i_pe_data,
  input  logic [SIMD_DEGREE-1:0]              i_pe_tvalid,
  input  logic [SIMD_DEGREE-1:0]              i_pe_tlast,
  output logic [SIMD_DEGREE*DWIDTH-1:0]       m_axis_tdata,
  output logic [SIMD_DEGREE*DWIDTH/8-1:0]     m_axis_tkeep,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                o_almost_full,
  output logic [$clog2(DEPTH+1)-1:0]          o_fifo_count,
  output logic                                o_err_overrun,
  output logic                                o_err_overflow,
  output logic                                o_err_tlast
);

  localparam int CW   = $clog2(DEPTH+1);
  localparam int PW   = $clog2(DEPTH);
  localparam int PHIT = SIMD_DEGREE*DWIDTH;
  localparam int KW   = PHIT/8;

  logic [DWIDTH-1:0]      lane_data [SIMD_DEGREE];
  logic [SIMD_DEGREE-1:0] lane_last;
  logic [SIMD_DEGREE-1:0] held;

  logic [PHIT-1:0]        asm_data;
  logic [SIMD_DEGREE-1:0] asm_last;
  logic                   complete;
  logic                   overrun_now;
  logic                   phit_last;
  logic                   tlast_mismatch;

  logic [PHIT:0]          mem [DEPTH];
  logic [PHIT:0]          head;
  logic [PW-1:0]          wptr;
  logic [PW-1:0]          rptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic                   pop;
  logic                   push_ok;
  logic                   overflow_now;

  // Assemble the candidate phit: held lanes come from registers, the rest bypass from this cycle's inputs
  always_comb begin
    asm_data = '0;
    asm_last = '0;
    for (int i = 0; i < SIMD_DEGREE; i++) begin
      asm_data[i*DWIDTH +: DWIDTH] = held[i] ? lane_data[i] : i_pe_data[i*DWIDTH +: DWIDTH];
      asm_last[i]                  = held[i] ? lane_last[i] : i_pe_tlast[i];
    end
    complete       = &(held | i_pe_tvalid);
    overrun_now    = |(held & i_pe_tvalid);
    phit_last      = |asm_last;
    tlast_mismatch = complete & phit_last & ~(&asm_last);
  end

  // Per-lane holding registers; a second valid on an already-held lane is dropped so the first result wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held      <= '0;
      lane_last <= '0;
      for (int i = 0; i < SIMD_DEGREE; i++) lane_data[i] <= '0;
    end else if (complete) begin
      held <= '0;
    end else begin
      for (int i = 0; i < SIMD_DEGREE; i++) begin
        if (i_pe_tvalid[i] && !held[i]) begin
          lane_data[i] <= i_pe_data[i*DWIDTH +: DWIDTH];
          lane_last[i] <= i_pe_tlast[i];
          held[i]      <= 1'b1;
        end
      end
    end
  end

  // FIFO push/pop decisions; a full FIFO still accepts when a pop frees the slot on the same edge
  always_comb begin
    pop          = (count != '0) & m_axis_tready;
    push_ok      = complete & ((count != CW'(DEPTH)) | pop);
    overflow_now = complete & ~push_ok;
    count_next   = count;
    if (push_ok && !pop)      count_next = count + 1'b1;
    else if (!push_ok && pop) count_next = count - 1'b1;
  end

  // Phit storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= {phit_last, asm_data};
  end

  // Pointers, occupancy, registered almost_full and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      o_almost_full  <= 1'b0;
      o_err_overrun  <= 1'b0;
      o_err_overflow <= 1'b0;
      o_err_tlast    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count         <= count_next;
      o_almost_full <= (CW'(DEPTH) - count_next) <= CW'(AFULL_SLACK);
      if (overrun_now)    o_err_overrun  <= 1'b1;
      if (overflow_now)   o_err_overflow <= 1'b1;
      if (tlast_mismatch) o_err_tlast    <= 1'b1;
    end
  end

  // First-word-fall-through output; data is forced to zero whenever nothing is presented
  always_comb begin
    head          = mem[rptr];
    m_axis_tvalid = (count != '0);
    m_axis_tdata  = m_axis_tvalid ? head[PHIT-1:0] : '0;
    m_axis_tlast  = m_axis_tvalid & head[PHIT];
    m_axis_tkeep  = {KW{m_axis_tvalid}};
    o_fifo_count  = count;
  end

endmodule
